csr_cmd_sequencer: RTL and testbench

CSR_CMD_SEQUENCER -- requirements
Module: csr_cmd_sequencer

---
 rtl/csr_cmd_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_csr_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_cmd_sequencer.sv
// SPI command sequencer that turns received bytes into CSR read/write strobes.
// Command byte layout: {op[1:0], addr[ADDR_WIDTH-1:0]}.
// Optional feature macro: CSR_SEQ_BURST_EN builds the burst-write state for op 11;
// without it op 11 is flagged as an error.
module csr_cmd_sequencer #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  tx_valid,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_we,
    output logic                  csr_re,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WDATA  = 3'd2,
        RD_REQ = 3'd3,
        RD_CAP = 3'd4,
`ifdef CSR_SEQ_BURST_EN
        BURST  = 3'd6,
`endif
        DRAIN  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_csr_addr;
    logic [DATA_WIDTH-1:0] r_csr_wdata;
    logic [DATA_WIDTH-1:0] r_tx_byte;
    logic                  r_tx_valid;
    logic                  r_csr_we;
    logic                  r_csr_re;
    logic                  r_busy;
    logic                  r_err;

    logic [1:0]            w_cmd_op;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic                  w_addr_ok;
    logic                  w_rx_ok;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_csr_addr;
    logic [DATA_WIDTH-1:0] w_csr_wdata;
    logic [DATA_WIDTH-1:0] w_tx_byte;
    logic                  w_tx_valid;
    logic                  w_csr_we;
    logic                  w_csr_re;
    logic                  w_err;
`ifdef CSR_SEQ_BURST_EN
    logic [ADDR_WIDTH-1:0] w_addr_inc;
`endif

    assign w_cmd_op   = rx_byte[ADDR_WIDTH +: 2];
    assign w_cmd_addr = rx_byte[ADDR_WIDTH-1:0];
    assign w_addr_ok  = (32'(w_cmd_addr) < DEPTH);
    // A byte arriving as frame falls belongs to no transaction.
    assign w_rx_ok    = rx_valid & frame;
`ifdef CSR_SEQ_BURST_EN
    assign w_addr_inc = (32'(r_addr) == DEPTH - 1) ? '0 : r_addr + ADDR_WIDTH'(1);
`endif

    // Next-state and next-output decode; everything holds unless a case says otherwise.
    always_comb begin
        w_next      = r_state;
        w_addr      = r_addr;
        w_csr_addr  = r_csr_addr;
        w_csr_wdata = r_csr_wdata;
        w_tx_byte   = r_tx_byte;
        w_tx_valid  = 1'b0;
        w_csr_we    = 1'b0;
        w_csr_re    = 1'b0;
        w_err       = r_err;
        case (r_state)
            IDLE: begin
                if (frame) begin
                    w_next = CMD;
                    w_err  = 1'b0;
                end
            end
            CMD: begin
                if (!frame) begin
                    w_next = IDLE;
                end else if (rx_valid) begin
                    w_addr     = w_cmd_addr;
                    w_csr_addr = w_cmd_addr;
                    if (!w_addr_ok) begin
                        w_err  = 1'b1;
                        w_next = DRAIN;
                    end else begin
                        case (w_cmd_op)
                            OP_NOP:   w_next = DRAIN;
                            OP_READ: begin
                                // Strobe goes out with the state change so data returns in RD_CAP.
                                w_csr_re = 1'b1;
                                w_next   = RD_REQ;
                            end
                            OP_WRITE: w_next = WDATA;
                            default: begin
`ifdef CSR_SEQ_BURST_EN
                                w_next = BURST;
`else
                                w_err  = 1'b1;
                                w_next = DRAIN;
`endif
                            end
                        endcase
                    end
                end
            end
            WDATA: begin
                if (!frame) begin
                    w_next = IDLE;
                end else if (rx_valid) begin
                    w_csr_we    = 1'b1;
                    w_csr_addr  = r_addr;
                    w_csr_wdata = rx_byte;
                    w_next      = DRAIN;
                end
            end
            RD_REQ: begin
                // The read is already on the bus, so it completes even if frame drops.
                if (w_rx_ok) begin
                    w_err = 1'b1;
                end
                w_next = RD_CAP;
            end
            RD_CAP: begin
                if (w_rx_ok) begin
                    w_err = 1'b1;
                end
                w_tx_byte  = csr_rdata;
                w_tx_valid = 1'b1;
                w_next     = frame ? DRAIN : IDLE;
            end
`ifdef CSR_SEQ_BURST_EN
            BURST: begin
                if (!frame) begin
                    w_next = IDLE;
                end else if (rx_valid) begin
                    w_csr_we    = 1'b1;
                    w_csr_addr  = r_addr;
                    w_csr_wdata = rx_byte;
                    w_addr      = w_addr_inc;
                end
            end
`endif
            DRAIN: begin
                if (!frame) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_tx_byte   <= '0;
            r_tx_valid  <= 1'b0;
            r_csr_we    <= 1'b0;
            r_csr_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr      <= w_addr;
            r_csr_addr  <= w_csr_addr;
            r_csr_wdata <= w_csr_wdata;
            r_tx_byte   <= w_tx_byte;
            r_tx_valid  <= w_tx_valid;
            r_csr_we    <= w_csr_we;
            r_csr_re    <= w_csr_re;
            r_busy      <= (w_next != IDLE);
            r_err       <= w_err;
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_valid  = r_tx_valid;
    assign csr_addr  = r_csr_addr;
    assign csr_wdata = r_csr_wdata;
    assign csr_we    = r_csr_we;
    assign csr_re    = r_csr_re;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_csr_cmd_sequencer.sv
// Directed bench for csr_cmd_sequencer: default instance plus a DEPTH=16 instance.
// Burst expectations follow whether CSR_SEQ_BURST_EN is defined for the build.
module tb_csr_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       frame;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [5:0] csr_addr;
    logic [7:0] csr_wdata;
    logic       csr_we;
    logic       csr_re;
    logic [7:0] csr_rdata;
    logic       busy;
    logic       err;

    logic [7:0] d16_tx_byte;
    logic       d16_tx_valid;
    logic [5:0] d16_csr_addr;
    logic [7:0] d16_csr_wdata;
    logic       d16_csr_we;
    logic       d16_csr_re;
    logic [7:0] d16_rdata;
    logic       d16_busy;
    logic       d16_err;

    logic [7:0] mem [0:63];
    logic [5:0] wlog_addr [$];
    logic [7:0] wlog_data [$];
    int         both_cnt;
    int         d16_we_cnt;
    int         n_pass;
    int         n_checks;

    csr_cmd_sequencer dut (
        .clk(clk), .rst(rst), .frame(frame), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_we(csr_we), .csr_re(csr_re), .csr_rdata(csr_rdata), .busy(busy), .err(err)
    );

    csr_cmd_sequencer #(.DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .frame(frame), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(d16_tx_byte), .tx_valid(d16_tx_valid), .csr_addr(d16_csr_addr),
        .csr_wdata(d16_csr_wdata), .csr_we(d16_csr_we), .csr_re(d16_csr_re),
        .csr_rdata(d16_rdata), .busy(d16_busy), .err(d16_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: read data valid the cycle after csr_re.
    always @(posedge clk) begin
        if (csr_re) csr_rdata <= mem[csr_addr];
    end

    // Write logger and strobe-exclusion monitor.
    always @(negedge clk) begin
        if (csr_we) begin
            wlog_addr.push_back(csr_addr);
            wlog_data.push_back(csr_wdata);
        end
        if (csr_we && csr_re) both_cnt++;
        if (d16_csr_we) d16_we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        frame = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        frame = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got %h exp 00", tx_byte); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else n_pass++;
        n_checks++; if (csr_addr !== 6'h00) $display("FAIL reset_csr_addr got %h exp 00", csr_addr); else n_pass++;
        n_checks++; if (csr_wdata !== 8'h00) $display("FAIL reset_csr_wdata got %h exp 00", csr_wdata); else n_pass++;
        n_checks++; if ({csr_we, csr_re} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {csr_we, csr_re}); else n_pass++;
        n_checks++; if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err got %b exp 00", {busy, err}); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        clear_log();
        frame_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL write_busy got %b exp 1", busy); else n_pass++;
        send_byte(8'h85);
        send_byte(8'h3C);
        n_checks++; if ({csr_we, csr_addr, csr_wdata} !== {1'b1, 6'd5, 8'h3C})
            $display("FAIL write_strobe got we=%b a=%0d d=%h exp we=1 a=5 d=3c", csr_we, csr_addr, csr_wdata); else n_pass++;
        tick();
        n_checks++; if (csr_we !== 1'b0) $display("FAIL write_one_cycle got %b exp 0", csr_we); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL write_err got %b exp 0", err); else n_pass++;
        frame_end();
        n_checks++; if (wlog_addr.size() !== 1) $display("FAIL write_count got %0d exp 1", wlog_addr.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL write_idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_read();
        clear_log();
        frame_start();
        send_byte(8'h43);
        n_checks++; if ({csr_re, csr_we, csr_addr} !== {1'b1, 1'b0, 6'd3})
            $display("FAIL read_req got re=%b we=%b a=%0d exp re=1 we=0 a=3", csr_re, csr_we, csr_addr); else n_pass++;
        tick();
        n_checks++; if ({csr_re, tx_valid} !== 2'b00) $display("FAIL read_cap got re/txv=%b exp 00", {csr_re, tx_valid}); else n_pass++;
        tick();
        n_checks++; if ({tx_valid, tx_byte} !== {1'b1, 8'hA7})
            $display("FAIL read_tx got v=%b d=%h exp v=1 d=a7", tx_valid, tx_byte); else n_pass++;
        tick();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL read_tx_pulse got %b exp 0", tx_valid); else n_pass++;
        frame_end();
        n_checks++; if (wlog_addr.size() !== 0) $display("FAIL read_no_write got %0d exp 0", wlog_addr.size()); else n_pass++;
    endtask

    task automatic test_bad_addr();
        d16_we_cnt = 0;
        frame_start();
        send_byte(8'h9F);
        n_checks++; if (d16_err !== 1'b1) $display("FAIL badaddr_err got %b exp 1", d16_err); else n_pass++;
        send_byte(8'h55);
        tick();
        n_checks++; if (d16_we_cnt !== 0) $display("FAIL badaddr_no_we got %0d exp 0", d16_we_cnt); else n_pass++;
        frame_end();
        n_checks++; if (d16_err !== 1'b1) $display("FAIL badaddr_sticky got %b exp 1", d16_err); else n_pass++;
        frame_start();
        n_checks++; if (d16_err !== 1'b0) $display("FAIL badaddr_clear got %b exp 0", d16_err); else n_pass++;
        frame_end();
        clear_log();
    endtask

    task automatic test_burst();
        clear_log();
        frame_start();
`ifdef CSR_SEQ_BURST_EN
        send_byte(8'hDE);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        tick();
        n_checks++; if (wlog_addr.size() !== 3) $display("FAIL burst_count got %0d exp 3", wlog_addr.size()); else n_pass++;
        n_checks++; if ({wlog_addr[0], wlog_addr[1], wlog_addr[2]} !== {6'd30, 6'd31, 6'd0})
            $display("FAIL burst_addr got %0d %0d %0d exp 30 31 0", wlog_addr[0], wlog_addr[1], wlog_addr[2]); else n_pass++;
        n_checks++; if ({wlog_data[0], wlog_data[1], wlog_data[2]} !== 24'h112233)
            $display("FAIL burst_data got %h %h %h exp 11 22 33", wlog_data[0], wlog_data[1], wlog_data[2]); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL burst_err got %b exp 0", err); else n_pass++;
`else
        send_byte(8'hDE);
        n_checks++; if (err !== 1'b1) $display("FAIL noburst_err got %b exp 1", err); else n_pass++;
        send_byte(8'h11);
        send_byte(8'h22);
        tick();
        n_checks++; if (wlog_addr.size() !== 0) $display("FAIL noburst_no_we got %0d exp 0", wlog_addr.size()); else n_pass++;
`endif
        frame_end();
    endtask

    task automatic test_abort();
        clear_log();
        frame_start();
        send_byte(8'h87);
        frame    = 1'b0;
        rx_byte  = 8'h3C;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++; if ({busy, csr_we} !== 2'b00) $display("FAIL abort_idle got busy/we=%b exp 00", {busy, csr_we}); else n_pass++;
        tick();
        tick();
        n_checks++; if (wlog_addr.size() !== 0) $display("FAIL abort_no_we got %0d exp 0", wlog_addr.size()); else n_pass++;
    endtask

    task automatic test_drain();
        clear_log();
        frame_start();
        send_byte(8'h82);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        tick();
        frame_end();
        n_checks++; if (wlog_addr.size() !== 1) $display("FAIL drain_count got %0d exp 1", wlog_addr.size()); else n_pass++;
        n_checks++; if ({wlog_addr[0], wlog_data[0]} !== {6'd2, 8'h44})
            $display("FAIL drain_write got a=%0d d=%h exp a=2 d=44", wlog_addr[0], wlog_data[0]); else n_pass++;
    endtask

    task automatic test_read_err();
        clear_log();
        mem[9] = 8'h5E;
        frame_start();
        send_byte(8'h49);
        send_byte(8'h12);
        n_checks++; if (err !== 1'b1) $display("FAIL rderr_err got %b exp 1", err); else n_pass++;
        tick();
        n_checks++; if ({tx_valid, tx_byte} !== {1'b1, 8'h5E})
            $display("FAIL rderr_tx got v=%b d=%h exp v=1 d=5e", tx_valid, tx_byte); else n_pass++;
        frame_end();
        n_checks++; if (wlog_addr.size() !== 0) $display("FAIL rderr_no_we got %0d exp 0", wlog_addr.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        frame_start();
        send_byte(8'h85);
        rx_byte  = 8'h99;
        rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({busy, csr_addr, csr_we, csr_re, tx_valid, err} !== 11'd0)
            $display("FAIL rstmid_async got busy=%b a=%0d we=%b", busy, csr_addr, csr_we); else n_pass++;
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (wlog_addr.size() !== 0) $display("FAIL rstmid_no_we got %0d exp 0", wlog_addr.size()); else n_pass++;
        frame = 1'b0;
        tick();
        frame_start();
        send_byte(8'h81);
        send_byte(8'h5A);
        tick();
        frame_end();
        n_checks++; if (wlog_addr.size() !== 1 || wlog_data[0] !== 8'h5A || wlog_addr[0] !== 6'd1)
            $display("FAIL rstmid_fresh got n=%0d d=%h exp n=1 a=1 d=5a", wlog_addr.size(), wlog_data[0]); else n_pass++;
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_cnt !== 0) $display("FAIL we_re_overlap got %0d exp 0", both_cnt); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_checks   = 0;
        both_cnt   = 0;
        d16_we_cnt = 0;
        rst        = 1'b1;
        frame      = 1'b0;
        rx_byte    = 8'h00;
        rx_valid   = 1'b0;
        csr_rdata  = 8'h00;
        d16_rdata  = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        mem[3] = 8'hA7;
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_burst();
        test_abort();
        test_drain();
        test_read_err();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
